action_issue: RTL and testbench

- Transmit side of the action engine's input interface.
- Buffers PHVs from the key extractor while the match table computes their actions. Each returned action is paired with the oldest waiting PHV.
- Drives the PHV and its action to the stage's action engine in the same cycle, so both valids are asserted together.
- Sits between the lookup and the action engine in every stage. The action engine has no backpressure, so this block is the alignment point.

---
 rtl/rmt_pkg.sv | 16 +
 rtl/phv_sync_fifo.sv | 73 +++++++
 rtl/action_issue.sv | 89 ++++++++
 tb/tb_action_issue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_pkg.sv
// Shared widths and constants for the RMT pipeline stages.
// PHV layout: 8x48b + 8x32b + 8x16b containers plus 356b metadata/remain.
package rmt_pkg;

  localparam int C48_W   = 48;
  localparam int C32_W   = 32;
  localparam int C16_W   = 16;
  localparam int META_W  = 356;
  localparam int PHV_LEN = 8*C48_W + 8*C32_W + 8*C16_W + META_W;
  localparam int ACT_LEN = 25;
  localparam int ACT_NUM = 25;
  localparam int ACT_W   = ACT_LEN*ACT_NUM;

  localparam logic [ACT_W-1:0] NOP_ACTION = '0;

endpackage

// File: rtl/phv_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and flush.
// Full/empty come from the count so pointers can wrap freely.
module phv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             push;
  logic             pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push    = wr_en_i && !full_o && !flush_i;
  assign pop     = rd_en_i && !empty_o && !flush_i;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is left unreset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      cnt_q <= cnt_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = cnt_q;

endmodule

// File: rtl/action_issue.sv
// Pairs each returned action with the oldest buffered PHV and issues
// both to the action engine in the same cycle.
module action_issue #(
  parameter int STAGE      = 0,
  parameter int PHV_LEN    = rmt_pkg::PHV_LEN,
  parameter int ACT_LEN    = rmt_pkg::ACT_LEN,
  parameter int ACT_NUM    = rmt_pkg::ACT_NUM,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_valid_in,
  output logic                          phv_ready_out,
  input  logic [ACT_LEN*ACT_NUM-1:0]    action_in,
  input  logic                          action_valid_in,
  input  logic                          action_hit_in,
  input  logic                          flush_in,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic                          phv_valid_out,
  output logic [ACT_LEN*ACT_NUM-1:0]    action_out,
  output logic                          action_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_orphan,
  output logic                          err_overflow
);

  import rmt_pkg::*;

  localparam int AW_ACT = ACT_LEN*ACT_NUM;

  logic              full;
  logic              empty;
  logic              pop_req;
  logic              orphan;
  logic              overflow;
  logic              valid_d;
  logic              valid_q;
  logic [AW_ACT-1:0] act_d;
  logic [AW_ACT-1:0] act_q;
  logic              err_orphan_q;
  logic              err_overflow_q;

  phv_sync_fifo #(
    .WIDTH (PHV_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_in),
    .wr_en_i   (phv_valid_in),
    .wr_data_i (phv_in),
    .rd_en_i   (action_valid_in),
    .rd_data_o (phv_out),
    .count_o   (fifo_count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign phv_ready_out = !full;

  // Emptiness is judged before this cycle's push: no bypass path.
  assign pop_req  = action_valid_in && !empty;
  assign orphan   = action_valid_in && empty;
  assign overflow = phv_valid_in && full;
  assign valid_d  = pop_req && !flush_in;
  assign act_d    = action_hit_in ? action_in : AW_ACT'(NOP_ACTION);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q        <= 1'b0;
      act_q          <= '0;
      err_orphan_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (valid_d) act_q <= act_d;
      if (!flush_in && orphan)   err_orphan_q   <= 1'b1;
      if (!flush_in && overflow) err_overflow_q <= 1'b1;
    end
  end

  assign phv_valid_out    = valid_q;
  assign action_valid_out = valid_q;
  assign action_out       = act_q;
  assign err_orphan       = err_orphan_q;
  assign err_overflow     = err_overflow_q;

endmodule

// File: tb/tb_action_issue.sv
// Directed bench for action_issue with a queue-based reference model.
// Hand-computed literal checks pin each scenario.
module tb_action_issue;

  localparam int PW = 1124;
  localparam int AW = 625;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] phv_in;
  logic          phv_valid_in;
  logic          phv_ready_out;
  logic [AW-1:0] action_in;
  logic          action_valid_in;
  logic          action_hit_in;
  logic          flush_in;
  logic [PW-1:0] phv_out;
  logic          phv_valid_out;
  logic [AW-1:0] action_out;
  logic          action_valid_out;
  logic [3:0]    fifo_count;
  logic          err_orphan;
  logic          err_overflow;

  action_issue #(
    .STAGE      (0),
    .PHV_LEN    (PW),
    .ACT_LEN    (25),
    .ACT_NUM    (25),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .phv_in           (phv_in),
    .phv_valid_in     (phv_valid_in),
    .phv_ready_out    (phv_ready_out),
    .action_in        (action_in),
    .action_valid_in  (action_valid_in),
    .action_hit_in    (action_hit_in),
    .flush_in         (flush_in),
    .phv_out          (phv_out),
    .phv_valid_out    (phv_valid_out),
    .action_out       (action_out),
    .action_valid_out (action_valid_out),
    .fifo_count       (fifo_count),
    .err_orphan       (err_orphan),
    .err_overflow     (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] mq[$];
  logic [PW-1:0] exp_phv;
  logic [AW-1:0] exp_act;
  bit            exp_v;
  bit            exp_oo;
  bit            exp_ov;
  bit            armed = 0;

  task automatic chk(input string nm, input logic [PW-1:0] got,
                     input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got[127:0], exp[127:0]);
    end
  endtask

  // Reference behaviour at a rising edge, from the pre-edge inputs.
  task automatic model_edge();
    int n;
    if (!rst_n) begin
      mq.delete();
      exp_v = 0; exp_phv = '0; exp_act = '0;
      exp_oo = 0; exp_ov = 0;
      armed = 1;
    end else if (flush_in) begin
      mq.delete();
      exp_v = 0;
    end else begin
      n = mq.size();
      exp_v = 0;
      if (action_valid_in && n != 0) begin
        exp_phv = mq.pop_front();
        exp_act = action_hit_in ? action_in : '0;
        exp_v = 1;
      end
      if (action_valid_in && n == 0) exp_oo = 1;
      if (phv_valid_in && n < DEPTH) mq.push_back(phv_in);
      if (phv_valid_in && n == DEPTH) exp_ov = 1;
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("valid", PW'(phv_valid_out), PW'(exp_v));
      chk("act_valid", PW'(action_valid_out), PW'(exp_v));
      chk("count", PW'(fifo_count), PW'(mq.size()));
      chk("ready", PW'(phv_ready_out), PW'(mq.size() != DEPTH));
      chk("phv_out", phv_out, exp_phv);
      chk("action_out", PW'(action_out), PW'(exp_act));
      chk("err_orphan", PW'(err_orphan), PW'(exp_oo));
      chk("err_overflow", PW'(err_overflow), PW'(exp_ov));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1; flush_in = 0;
    phv_valid_in = 0; action_valid_in = 0; action_hit_in = 0;
  endtask

  task automatic act(input logic [AW-1:0] a, input bit hit);
    action_valid_in = 1; action_in = a; action_hit_in = hit;
  endtask

  task automatic push(input logic [PW-1:0] p);
    phv_valid_in = 1; phv_in = p;
  endtask

  initial begin
    phv_in = '0; action_in = '0;
    idle();
    rst_n = 0;
    tick();
    tick();
    chk("rst_count", PW'(fifo_count), PW'(0));
    chk("rst_ready", PW'(phv_ready_out), PW'(1));
    chk("rst_phv", phv_out, PW'(0));
    idle();

    // In-order pairing with hit
    for (int i = 0; i < 3; i++) begin
      push(PW'(8'hA1 + i)); tick();
    end
    chk("s1_cnt3", PW'(fifo_count), PW'(3));
    idle(); tick();
    for (int i = 0; i < 3; i++) begin
      act(AW'(8'h11 + i), 1); tick();
      chk("s1_valid", PW'(phv_valid_out), PW'(1));
      chk("s1_phv", phv_out, PW'(8'hA1 + i));
      chk("s1_act", PW'(action_out), PW'(8'h11 + i));
      chk("s1_cnt", PW'(fifo_count), PW'(2 - i));
    end
    idle(); tick();
    chk("s1_off", PW'(phv_valid_out), PW'(0));
    chk("s1_hold", phv_out, PW'(8'hA3));

    // Miss yields the no-op action
    push(PW'(8'hB0)); tick();
    idle(); tick();
    act(AW'(8'h55), 0); tick();
    chk("s2_phv", phv_out, PW'(8'hB0));
    chk("s2_act", PW'(action_out), PW'(0));
    chk("s2_valid", PW'(phv_valid_out), PW'(1));
    idle(); tick();
    chk("s2_one", PW'(phv_valid_out), PW'(0));

    // Overflow then drain
    for (int i = 0; i < 9; i++) begin
      push(PW'(8'hC0 + i)); tick();
      if (i == 7) chk("s3_ready", PW'(phv_ready_out), PW'(0));
      if (i == 8) begin
        chk("s3_ovf", PW'(err_overflow), PW'(1));
        chk("s3_cnt", PW'(fifo_count), PW'(8));
      end
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      act(AW'(12'h100 + i), 1); tick();
      chk("s3_phv", phv_out, PW'(8'hC0 + i));
    end
    idle(); tick();

    // Orphan with same-cycle push
    push(PW'(8'hD0)); act(AW'(8'h77), 1); tick();
    chk("s4_noout", PW'(phv_valid_out), PW'(0));
    chk("s4_orphan", PW'(err_orphan), PW'(1));
    chk("s4_cnt", PW'(fifo_count), PW'(1));
    idle(); act(AW'(8'h78), 1); tick();
    chk("s4_phv", phv_out, PW'(8'hD0));
    idle(); tick();

    // Streaming with 3-cycle lookup latency, pointer wrap
    for (int t = 0; t < 23; t++) begin
      idle();
      if (t < 20) push(PW'(12'hE00 + t));
      if (t >= 3) act(AW'(12'h200 + t - 3), 1);
      tick();
      if (t >= 2 && t < 20) chk("s5_cnt", PW'(fifo_count), PW'(3));
      if (t >= 3) begin
        chk("s5_phv", phv_out, PW'(12'hE00 + t - 3));
        chk("s5_act", PW'(action_out), PW'(12'h200 + t - 3));
      end
    end
    idle(); tick();

    // Flush keeps error flags
    for (int i = 0; i < 5; i++) begin
      push(PW'(8'hF0 + i)); tick();
    end
    idle(); flush_in = 1; push(PW'(8'hFF)); act(AW'(8'h99), 1); tick();
    chk("s6_fl_cnt", PW'(fifo_count), PW'(0));
    chk("s6_fl_valid", PW'(phv_valid_out), PW'(0));
    chk("s6_fl_ovf", PW'(err_overflow), PW'(1));
    chk("s6_fl_orph", PW'(err_orphan), PW'(1));
    idle(); tick();

    // Reset mid-operation clears everything
    for (int i = 0; i < 5; i++) begin
      push(PW'(8'hF0 + i)); tick();
    end
    idle(); rst_n = 0; act(AW'(8'h9A), 1); tick();
    chk("s6_rs_cnt", PW'(fifo_count), PW'(0));
    chk("s6_rs_valid", PW'(phv_valid_out), PW'(0));
    chk("s6_rs_ovf", PW'(err_overflow), PW'(0));
    chk("s6_rs_orph", PW'(err_orphan), PW'(0));
    chk("s6_rs_phv", phv_out, PW'(0));
    idle(); tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
